// File: rtl/tl_sensor_queue.sv
// tl_sensor_queue: sensor-side traffic model for the left-turn light controller.
// Four identical lanes (A straight, A left, B straight, B left) each keep a
// car count and a departure timer. Cars leave only while their lane's light
// allows it. Occupancy flags, sticky overflow flags and a sticky
// conflicting-lights flag are reported back to the controller.
// Lane index order everywhere: 0 = a, 1 = al, 2 = b, 3 = bl.
module tl_sensor_queue #(
    parameter int CW        = 4,
    parameter int START_DLY = 1,
    parameter int DRAIN_DIV = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arr_a,
    input  logic          arr_al,
    input  logic          arr_b,
    input  logic          arr_bl,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    output logic          Ta,
    output logic          Tal,
    output logic          Tb,
    output logic          Tbl,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_al,
    output logic [CW-1:0] cnt_b,
    output logic [CW-1:0] cnt_bl,
    output logic [3:0]    ovf,
    output logic          conflict
);

    // The timer must hold both the start delay and the inter-departure reload.
    localparam int TMAX = (START_DLY > (DRAIN_DIV - 1)) ? START_DLY : (DRAIN_DIV - 1);
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic [TW-1:0] TMR_START  = TW'(START_DLY);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(DRAIN_DIV - 1);
    localparam logic [TW-1:0] TMR_ZERO   = '0;
    localparam logic [TW-1:0] TMR_ONE    = TW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_RED    = 2'b10;
    localparam logic [1:0] LIGHT_LEFT   = 2'b11;

    logic [3:0]           arr;
    logic [3:0]           dep;
    logic [3:0]           en_d,  en_q;
    logic [3:0][TW-1:0]   tmr_d, tmr_q;
    logic [3:0][CW-1:0]   cnt_d, cnt_q;
    logic [3:0]           ovf_d, ovf_q;
    logic                 conflict_d, conflict_q;

    assign arr = {arr_bl, arr_b, arr_al, arr_a};

    // Next-state logic: the sampled light enables the lane one cycle later, so
    // the first car leaves START_DLY+1 edges after the green is sampled.
    always_comb begin
        en_d       = {(Lb == LIGHT_LEFT), (Lb == LIGHT_GREEN),
                      (La == LIGHT_LEFT), (La == LIGHT_GREEN)};
        dep        = '0;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        conflict_d = conflict_q | ((La != LIGHT_RED) && (Lb != LIGHT_RED));

        for (int i = 0; i < 4; i++) begin
            dep[i] = en_q[i] && (tmr_q[i] == TMR_ZERO) && (cnt_q[i] != CNT_ZERO);

            if (!en_q[i]) begin
                tmr_d[i] = TMR_START;
            end else if (tmr_q[i] != TMR_ZERO) begin
                tmr_d[i] = tmr_q[i] - TMR_ONE;
            end else if (dep[i]) begin
                tmr_d[i] = TMR_RELOAD;
            end else begin
                tmr_d[i] = TMR_ZERO;
            end

            if (arr[i] && !dep[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dep[i] && !arr[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // State registers; reset empties every queue immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= '0;
            tmr_q      <= {4{TMR_START}};
            cnt_q      <= '0;
            ovf_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            en_q       <= en_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            conflict_q <= conflict_d;
        end
    end

    assign cnt_a    = cnt_q[0];
    assign cnt_al   = cnt_q[1];
    assign cnt_b    = cnt_q[2];
    assign cnt_bl   = cnt_q[3];
    assign Ta       = (cnt_q[0] != CNT_ZERO);
    assign Tal      = (cnt_q[1] != CNT_ZERO);
    assign Tb       = (cnt_q[2] != CNT_ZERO);
    assign Tbl      = (cnt_q[3] != CNT_ZERO);
    assign ovf      = ovf_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_tl_sensor_queue.sv
// tb_tl_sensor_queue: scoreboard bench for tl_sensor_queue (CW=4,
// START_DLY=1, DRAIN_DIV=2). A cycle model predicts the outputs after each
// edge; predictions are queued when stimulus is driven and popped after the edge.
module tb_tl_sensor_queue;

    logic       clk;
    logic       reset_n;
    logic       arr_a, arr_al, arr_b, arr_bl;
    logic [1:0] La, Lb;
    logic       Ta, Tal, Tb, Tbl;
    logic [3:0] cnt_a, cnt_al, cnt_b, cnt_bl;
    logic [3:0] ovf;
    logic       conflict;

    typedef struct {
        logic [15:0] cnt;
        logic [3:0]  t;
        logic [3:0]  ovf;
        logic        conf;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int passes = 0;

    int m_cnt[4];
    int m_tmr[4];
    bit m_en[4];
    bit m_ovf[4];
    bit m_conf;

    tl_sensor_queue #(.CW(4), .START_DLY(1), .DRAIN_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .arr_a(arr_a), .arr_al(arr_al), .arr_b(arr_b), .arr_bl(arr_bl),
        .La(La), .Lb(Lb),
        .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
        .cnt_a(cnt_a), .cnt_al(cnt_al), .cnt_b(cnt_b), .cnt_bl(cnt_bl),
        .ovf(ovf), .conflict(conflict)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            passes++;
    endtask

    function automatic logic [15:0] dut_cnt();
        return {cnt_bl, cnt_b, cnt_al, cnt_a};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_tmr[i] = 1;
            m_en[i]  = 1'b0;
            m_ovf[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    // Advance the model by one edge for the given inputs and queue the result.
    task automatic model_step(input logic [3:0] arr, input logic [1:0] la, input logic [1:0] lb);
        exp_t e;
        bit   dep;
        bit   light[4];
        light[0] = (la == 2'b00);
        light[1] = (la == 2'b11);
        light[2] = (lb == 2'b00);
        light[3] = (lb == 2'b11);
        if (la != 2'b10 && lb != 2'b10) m_conf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dep = m_en[i] && m_tmr[i] == 0 && m_cnt[i] > 0;
            if (!m_en[i])          m_tmr[i] = 1;
            else if (m_tmr[i] > 0) m_tmr[i] = m_tmr[i] - 1;
            else if (dep)          m_tmr[i] = 1;
            if (arr[i] && !dep) begin
                if (m_cnt[i] == 15) m_ovf[i] = 1'b1;
                else                m_cnt[i]++;
            end else if (dep && !arr[i]) begin
                m_cnt[i]--;
            end
            m_en[i] = light[i];
        end
        for (int i = 0; i < 4; i++) begin
            e.cnt[i*4 +: 4] = 4'(m_cnt[i]);
            e.t[i]          = (m_cnt[i] != 0);
            e.ovf[i]        = m_ovf[i];
        end
        e.conf = m_conf;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, then compare against the scoreboard after the edge.
    task automatic apply_stimulus(input logic [3:0] arr, input logic [1:0] la, input logic [1:0] lb);
        exp_t e;
        {arr_bl, arr_b, arr_al, arr_a} = arr;
        La = la;
        Lb = lb;
        model_step(arr, la, lb);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_output("sb_cnt",      32'(dut_cnt()), 32'(e.cnt));
        check_output("sb_t",        32'({Tbl, Tb, Tal, Ta}), 32'(e.t));
        check_output("sb_ovf",      32'(ovf), 32'(e.ovf));
        check_output("sb_conflict", 32'(conflict), 32'(e.conf));
        {arr_bl, arr_b, arr_al, arr_a} = 4'b0000;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_cnt"},      32'(dut_cnt()), 32'h0);
        check_output({tag, "_t"},        32'({Tbl, Tb, Tal, Ta}), 32'h0);
        check_output({tag, "_ovf"},      32'(ovf), 32'h0);
        check_output({tag, "_conflict"}, 32'(conflict), 32'h0);
    endtask

    initial begin
        int drain_exp[7];
        drain_exp = '{3, 3, 2, 2, 1, 1, 0};

        reset_n = 1'b0;
        {arr_bl, arr_b, arr_al, arr_a} = 4'b0000;
        La = 2'b10;
        Lb = 2'b10;
        model_reset();
        #12;
        check_reset_state("init_reset");
        reset_n = 1'b1;

        // Three cars queue on A straight while A is red.
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0001, 2'b10, 2'b00);
        for (int i = 0; i < 5; i++) apply_stimulus(4'b0000, 2'b10, 2'b00);
        check_output("red_hold_cnt_a", 32'(cnt_a), 32'd3);
        check_output("red_hold_Ta",    32'(Ta), 32'd1);

        // Green sampled at edge 0; cars leave at edges 2, 4, 6.
        for (int e = 0; e < 7; e++) begin
            apply_stimulus(4'b0000, 2'b00, 2'b10);
            check_output($sformatf("drain_edge%0d_cnt_a", e), 32'(cnt_a), 32'(drain_exp[e]));
        end
        check_output("drain_Ta_low", 32'(Ta), 32'd0);
        apply_stimulus(4'b0000, 2'b00, 2'b10);

        // Arrival on a departure edge and a left-lane arrival under green.
        apply_stimulus(4'b0001, 2'b10, 2'b10);
        apply_stimulus(4'b0001, 2'b10, 2'b10);
        apply_stimulus(4'b0000, 2'b00, 2'b10);
        apply_stimulus(4'b0000, 2'b00, 2'b10);
        apply_stimulus(4'b0011, 2'b00, 2'b10);
        check_output("simul_cnt_a",  32'(cnt_a), 32'd2);
        check_output("simul_cnt_al", 32'(cnt_al), 32'd1);
        for (int i = 0; i < 6; i++) apply_stimulus(4'b0000, 2'b00, 2'b10);
        check_output("simul_drained_cnt_a", 32'(cnt_a), 32'd0);

        // Overflow on B left lane, then drain on the B left arrow.
        for (int i = 0; i < 16; i++) apply_stimulus(4'b1000, 2'b10, 2'b10);
        check_output("ovf_cnt_bl", 32'(cnt_bl), 32'd15);
        check_output("ovf_flag",   32'(ovf), 32'b1000);
        for (int i = 0; i < 40; i++) apply_stimulus(4'b0000, 2'b10, 2'b11);
        check_output("ovf_drained_cnt_bl", 32'(cnt_bl), 32'd0);
        check_output("ovf_sticky",         32'(ovf), 32'b1000);

        // Conflict: yellow against red is legal, green against yellow is not.
        check_output("conflict_clear", 32'(conflict), 32'd0);
        apply_stimulus(4'b0000, 2'b01, 2'b10);
        check_output("conflict_yellow_red", 32'(conflict), 32'd0);
        apply_stimulus(4'b0000, 2'b00, 2'b01);
        check_output("conflict_set", 32'(conflict), 32'd1);
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 2'b10, 2'b10);
        check_output("conflict_held", 32'(conflict), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++)
            apply_stimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

        // Asynchronous reset with every queue at 5.
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(4'b1111, 2'b10, 2'b10);
        check_output("pre_reset_cnt", 32'(dut_cnt()), 32'h5555);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0001, 2'b00, 2'b10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
